lag_glyph_sequencer: RTL and testbench

- Per-scanline sequencer for the shared char_rom in the lag-display overlay.
- On a start pulse near line start, snapshots the BCD vector and glyph row, then walks NUM_FIELDS fields of DIGITS BCD digits each.
- For each digit: issues a char_rom address, captures the returned glyph byte after the ROM latency, and emits an indexed write to the overlay line buffer.
- Fields holding their "no value" code are skipped, so the line-buffer template stays visible for them.

---
 rtl/lag_glyph_sequencer.sv | 164 ++++++++++++++++
 tb/tb_lag_glyph_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_glyph_sequencer.sv
// Scanline glyph sequencer: walks snapshotted BCD fields through the shared char_rom
// and emits indexed glyph-byte writes into the overlay line buffer.

module lag_glyph_blank_det #(
  parameter int              FW         = 20,
  parameter logic [FW-1:0]   BLANK_CODE = '1,
  parameter bit              ZERO_BLANK = 1'b0
) (
  input  logic [FW-1:0] value_i,
  output logic          blank_o
);
  assign blank_o = (value_i == BLANK_CODE) || (ZERO_BLANK && (value_i == '0));
endmodule

module lag_glyph_sequencer #(
  parameter int                          NUM_FIELDS      = 4,
  parameter int                          DIGITS          = 5,
  parameter int                          ROM_LATENCY     = 2,
  parameter logic [DIGITS*4-1:0]         BLANK_CODE      = 20'hFFFFF,
  parameter logic [NUM_FIELDS-1:0]       ZERO_BLANK_MASK = 4'b0100
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [3:0]                       glyph_row,
  input  logic [NUM_FIELDS*DIGITS*4-1:0]   bcdcount,
  output logic [7:0]                       char_addr,
  input  logic [7:0]                       char_data,
  output logic                             wr_en,
  output logic [4:0]                       wr_idx,
  output logic [7:0]                       wr_data,
  output logic                             busy,
  output logic                             done
);
  localparam int FW  = DIGITS * 4;
  localparam int FCW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DCW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t                          state_q;
  logic [NUM_FIELDS*FW-1:0]        snap_bcd_q;
  logic [3:0]                      snap_row_q;
  logic [FCW-1:0]                  fld_q, fld_d;
  logic [DCW-1:0]                  dig_q, dig_d;
  logic [7:0]                      char_addr_q;
  logic                            busy_q, done_q;
  logic [ROM_LATENCY:0]            vld_pipe;
  logic [ROM_LATENCY:0][4:0]       idx_pipe;

  logic [NUM_FIELDS-1:0][FW-1:0]   fields_w;
  logic [DIGITS-1:0][3:0]          digs_w;
  logic [NUM_FIELDS-1:0]           blank_w;
  logic [3:0]                      cur_digit_w;
  logic [4:0]                      cur_idx_w;
  logic                            issue_w, last_fld_w, last_dig_w, pipe_busy_w;

  assign fields_w    = snap_bcd_q;
  assign digs_w      = fields_w[fld_q];
  assign cur_digit_w = digs_w[dig_q];
  assign cur_idx_w   = 5'(fld_q) * 5'(DIGITS) + 5'(dig_q);
  assign fld_d       = fld_q + FCW'(1);
  assign dig_d       = dig_q + DCW'(1);
  assign last_fld_w  = (fld_q == FCW'(NUM_FIELDS - 1));
  assign last_dig_w  = (dig_q == DCW'(DIGITS - 1));
  assign issue_w     = (state_q == S_ISSUE);
  assign pipe_busy_w = |vld_pipe;

  // One blank detector per field, evaluated against the snapshot.
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_blank
    lag_glyph_blank_det #(
      .FW        (FW),
      .BLANK_CODE(BLANK_CODE),
      .ZERO_BLANK(ZERO_BLANK_MASK[f])
    ) u_blank (
      .value_i(fields_w[f]),
      .blank_o(blank_w[f])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      snap_bcd_q  <= '0;
      snap_row_q  <= '0;
      fld_q       <= '0;
      dig_q       <= '0;
      char_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            snap_bcd_q <= bcdcount;
            snap_row_q <= glyph_row;
            fld_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!blank_w[fld_q]) begin
            dig_q   <= '0;
            state_q <= S_ISSUE;
          end else if (last_fld_w) begin
            state_q <= S_DRAIN;
          end else begin
            fld_q <= fld_d;
          end
        end
        S_ISSUE: begin
          char_addr_q <= {cur_digit_w, snap_row_q};
          if (last_dig_w) begin
            if (last_fld_w) begin
              state_q <= S_DRAIN;
            end else begin
              fld_q   <= fld_d;
              state_q <= S_CHECK;
            end
          end else begin
            dig_q <= dig_d;
          end
        end
        S_DRAIN: begin
          if (!pipe_busy_w) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Valid/index shift pipeline mirrors the ROM latency plus the address register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue_w;
      idx_pipe[0] <= issue_w ? cur_idx_w : 5'd0;
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign char_addr = char_addr_q;
  assign wr_en     = vld_pipe[ROM_LATENCY];
  assign wr_idx    = idx_pipe[ROM_LATENCY];
  // ROM output is only meaningful in the landing cycle, so pass it straight through.
  assign wr_data   = vld_pipe[ROM_LATENCY] ? char_data : 8'd0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lag_glyph_sequencer.sv
// Scoreboard bench: three sequencers (ROM latency 1,2,3) share stimulus; a rule-level
// model predicts writes/done/busy per instance and a negedge monitor checks them.

module tb_lag_glyph_sequencer;
  localparam int NI = 3;
  localparam logic [3:0] ZMASK = 4'b0100;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } wexp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  row = 4'd0;
  logic [79:0] bcd = '0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          npass = 0;
  int          ntot = 0;

  logic [7:0] ca_w [NI];
  logic       we_w [NI];
  logic [4:0] wi_w [NI];
  logic [7:0] wd_w [NI];
  logic       bz_w [NI];
  logic       dn_w [NI];

  wexp_t wq [NI][$];
  int    dq [NI][$];
  int    idle_from [NI];
  int    busy_lo [NI];
  int    busy_hi [NI];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [7:0] a);
    logic [7:0] p;
    p = a * 8'd29;
    return p ^ {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = k + 1;
    logic [7:0] ca, cd, wd;
    logic       we, bz, dn;
    logic [4:0] wi;
    logic [7:0] rom_pipe [L];

    always @(posedge clock) begin
      rom_pipe[0] <= rom(ca);
      for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign cd = rom_pipe[L-1];

    lag_glyph_sequencer #(.ROM_LATENCY(L)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .glyph_row(row),
      .bcdcount (bcd),
      .char_addr(ca),
      .char_data(cd),
      .wr_en    (we),
      .wr_idx   (wi),
      .wr_data  (wd),
      .busy     (bz),
      .done     (dn)
    );

    assign ca_w[k] = ca;
    assign we_w[k] = we;
    assign wi_w[k] = wi;
    assign wd_w[k] = wd;
    assign bz_w[k] = bz;
    assign dn_w[k] = dn;
  end

  task automatic chk(input string nm, input bit ok, input string act, input string req);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s @cyc %0d: got %s, expected %s", nm, cyc, act, req);
  endtask

  // Walk the fields by the cost rules: blank = 1 cycle, live = 1 check + DIGITS issues.
  task automatic model_run(input int k, input int t0, input logic [79:0] b, input logic [3:0] r);
    int t, last, lat, dn;
    logic [19:0] v;
    logic [3:0]  dg;
    bit blank;
    lat  = k + 1;
    t    = t0 + 1;
    last = -1;
    for (int f = 0; f < 4; f++) begin
      v = b[f*20 +: 20];
      blank = (v == 20'hFFFFF) || (ZMASK[f] && v == 20'h0);
      if (blank) t += 1;
      else begin
        for (int d = 0; d < 5; d++) begin
          dg = v[4*d +: 4];
          wq[k].push_back('{t + 1 + d + 1 + lat, f*5 + d, rom({dg, r})});
          last = t + 1 + d;
        end
        t += 6;
      end
    end
    if (last < 0) dn = t + 1;
    else dn = ((t > last + lat + 2) ? t : last + lat + 2) + 1;
    dq[k].push_back(dn);
    busy_lo[k]   = t0 + 1;
    busy_hi[k]   = dn;
    idle_from[k] = dn + 1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [79:0] b, input logic [3:0] r);
    bcd   = b;
    row   = r;
    start = 1'b1;
    for (int k = 0; k < NI; k++)
      if (cyc >= idle_from[k]) model_run(k, cyc, b, r);
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string nm);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_L%0d", nm, k + 1),
          ca_w[k] == 8'd0 && we_w[k] == 1'b0 && wi_w[k] == 5'd0 && wd_w[k] == 8'd0 &&
          bz_w[k] == 1'b0 && dn_w[k] == 1'b0,
          $sformatf("addr=%h en=%b idx=%0d data=%h busy=%b done=%b",
                    ca_w[k], we_w[k], wi_w[k], wd_w[k], bz_w[k], dn_w[k]),
          "all zero");
    end
  endtask

  // Reset asserted for the current cycle; takes effect at the next edge.
  task automatic reset_pulse();
    int c;
    c = cyc;
    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      while (wq[k].size() > 0 && wq[k][$].cyc > c) void'(wq[k].pop_back());
      while (dq[k].size() > 0 && dq[k][$] > c) void'(dq[k].pop_back());
      if (busy_hi[k] > c) busy_hi[k] = c;
      idle_from[k] = c + 1;
    end
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check_zero_outputs("reset_mid");
    tick();
  endtask

  task automatic wait_idle();
    int lim, hi;
    lim = cyc + 300;
    hi = 0;
    for (int k = 0; k < NI; k++) if (busy_hi[k] > hi) hi = busy_hi[k];
    while (cyc <= hi && cyc < lim) tick();
    if (cyc >= lim) chk("idle_timeout", 1'b0, "still busy", "idle");
  endtask

  function automatic logic [79:0] rand_bcd();
    logic [79:0] b;
    logic [19:0] v;
    for (int f = 0; f < 4; f++) begin
      case ($urandom_range(0, 3))
        0: v = 20'hFFFFF;
        1: v = 20'h0;
        2: for (int d = 0; d < 5; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
        default: v = 20'($urandom);
      endcase
      b[f*20 +: 20] = v;
    end
    return b;
  endfunction

  always @(negedge clock) begin
    wexp_t e;
    int    dc;
    bit    eb;
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        if (we_w[k]) begin
          if (wq[k].size() == 0)
            chk($sformatf("write_L%0d", k + 1), 1'b0,
                $sformatf("idx=%0d data=%h", wi_w[k], wd_w[k]), "no write");
          else begin
            e = wq[k].pop_front();
            chk($sformatf("write_L%0d", k + 1),
                e.cyc == cyc && e.idx == int'(wi_w[k]) && e.data == wd_w[k],
                $sformatf("cyc=%0d idx=%0d data=%h", cyc, wi_w[k], wd_w[k]),
                $sformatf("cyc=%0d idx=%0d data=%h", e.cyc, e.idx, e.data));
          end
        end
        while (wq[k].size() > 0 && wq[k][0].cyc < cyc) begin
          e = wq[k].pop_front();
          chk($sformatf("write_missing_L%0d", k + 1), 1'b0, "none",
              $sformatf("cyc=%0d idx=%0d", e.cyc, e.idx));
        end
        if (dn_w[k]) begin
          if (dq[k].size() == 0)
            chk($sformatf("done_L%0d", k + 1), 1'b0, "done pulse", "no done");
          else begin
            dc = dq[k].pop_front();
            chk($sformatf("done_L%0d", k + 1), dc == cyc,
                $sformatf("cyc=%0d", cyc), $sformatf("cyc=%0d", dc));
          end
        end
        while (dq[k].size() > 0 && dq[k][0] < cyc) begin
          dc = dq[k].pop_front();
          chk($sformatf("done_missing_L%0d", k + 1), 1'b0, "none", $sformatf("cyc=%0d", dc));
        end
        eb = (cyc >= busy_lo[k]) && (cyc <= busy_hi[k]);
        chk($sformatf("busy_L%0d", k + 1), bz_w[k] == eb,
            $sformatf("%b", bz_w[k]), $sformatf("%b", eb));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    logic [79:0] b;
    for (int k = 0; k < NI; k++) begin
      busy_lo[k] = 1;
      busy_hi[k] = 0;
    end
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int k = 0; k < NI; k++) idle_from[k] = cyc;
    @(negedge clock);
    check_zero_outputs("reset_state");
    mon_en = 1'b1;
    tick();

    // Full line, plus the first-address check.
    t0 = cyc;
    do_start({20'h00042, 20'h00099, 20'h00123, 20'h01234}, 4'd5);
    while (cyc < t0 + 3) tick();
    @(negedge clock);
    for (int k = 0; k < NI; k++)
      chk($sformatf("first_addr_L%0d", k + 1), ca_w[k] == 8'h45,
          $sformatf("%h", ca_w[k]), "45");
    tick();
    wait_idle();

    // Skip logic and all-blank.
    do_start({20'h00777, 20'h00000, 20'h05678, 20'hFFFFF}, 4'd9);
    wait_idle();
    do_start({20'hFFFFF, 20'h00000, 20'hFFFFF, 20'hFFFFF}, 4'd2);
    wait_idle();

    // Snapshot: inputs change and start repulses mid-run.
    t0 = cyc;
    do_start({20'h98765, 20'h43210, 20'h11111, 20'h24680}, 4'd12);
    while (cyc < t0 + 8) tick();
    do_start({20'h55555, 20'h66666, 20'h77777, 20'h88888}, 4'd3);
    wait_idle();

    // Start on a done cycle is ignored; the cycle after is accepted.
    t0 = cyc;
    do_start({20'h13579, 20'h00001, 20'h90000, 20'h31415}, 4'd7);
    while (cyc < t0 + 28) tick();
    do_start({20'h22222, 20'hFFFFF, 20'h33333, 20'h44444}, 4'd1);
    do_start({20'h12121, 20'h34343, 20'hFFFFF, 20'h56565}, 4'd14);
    wait_idle();

    // Reset mid-run, then a fresh run.
    t0 = cyc;
    do_start({20'h00042, 20'h00099, 20'h00123, 20'h01234}, 4'd5);
    while (cyc < t0 + 10) tick();
    reset_pulse();
    repeat (6) tick();
    do_start({20'h00042, 20'h00099, 20'h00123, 20'h01234}, 4'd11);
    wait_idle();

    // Randomized runs with occasional stray starts.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      b = rand_bcd();
      do_start(b, 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 8);
        repeat (n) tick();
        do_start(rand_bcd(), 4'($urandom));
      end
      wait_idle();
    end

    repeat (5) tick();
    for (int k = 0; k < NI; k++)
      chk($sformatf("leftover_L%0d", k + 1), wq[k].size() == 0 && dq[k].size() == 0,
          $sformatf("%0d writes %0d dones", wq[k].size(), dq[k].size()), "0 pending");
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
